// File: rtl/pump_pkg.sv
// Shared definitions for the pump controller: FSM states, fault codes,
// tank level codes and a level-code validity helper.
package pump_pkg;

  // Controller states; the encoding is visible on ctrl_state.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FILL    = 2'b01,
    HOLDOFF = 2'b10,
    FAULT   = 2'b11
  } state_t;

  // Latched fault reason reported on fault_code.
  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_SENSOR  = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_t;

  // One-hot tank level codes from the upstream level stage.
  localparam logic [2:0] LVL_LOW  = 3'b001;
  localparam logic [2:0] LVL_MED  = 3'b010;
  localparam logic [2:0] LVL_HIGH = 3'b100;

  // A level code is usable only if it is exactly one of the three levels;
  // all-zero and multi-hot codes mean a broken or shorted sensor.
  function automatic logic lvl_is_valid(input logic [2:0] lvl);
    logic ok;
    case (lvl)
      LVL_LOW:  ok = 1'b1;
      LVL_MED:  ok = 1'b1;
      LVL_HIGH: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/level_debounce.sv
// Level debouncer: a level code is accepted only after DEB_CYC consecutive
// identical samples. lvl_valid marks that at least one code has been accepted
// since reset, so the cleared 000 is not mistaken for a sensor fault.
module level_debounce
  import pump_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lvl_in,
  output logic [2:0] lvl_stable,
  output logic       lvl_valid
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEB_CYC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2:0]    sample;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Run-length of the current sample: reload on change, saturate when done.
  always_comb begin
    count_next = count;
    if (lvl_in != sample) begin
      count_next = CNT_ONE;
    end else if (count < CNT_DONE) begin
      count_next = count + CNT_ONE;
    end else begin
      count_next = count;
    end
  end

  // Sample history, run counter and the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample     <= 3'b000;
      count      <= '0;
      lvl_stable <= 3'b000;
      lvl_valid  <= 1'b0;
    end else begin
      sample <= lvl_in;
      count  <= count_next;
      if (count_next == CNT_DONE) begin
        lvl_stable <= lvl_in;
        lvl_valid  <= 1'b1;
      end else begin
        lvl_stable <= lvl_stable;
        lvl_valid  <= lvl_valid;
      end
    end
  end

endmodule

// File: rtl/pump_control.sv
// Tank fill controller: debounces the level code, runs the pump from low to
// high with a fill timeout, enforces a minimum off time after every stop and
// latches sensor/timeout faults until the operator acknowledges them.
module pump_control
  import pump_pkg::*;
#(
  parameter int DEB_CYC  = 4,
  parameter int FILL_MAX = 1000,
  parameter int OFF_MIN  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] water_level_state,
  input  logic       fault_ack,
  output logic       pump_on,
  output logic       alarm,
  output logic [1:0] fault_code,
  output logic [1:0] ctrl_state
);

  localparam int FW = $clog2(FILL_MAX + 1);
  localparam int OW = $clog2(OFF_MIN + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(FILL_MAX - 1);
  localparam logic [OW-1:0] OFF_LAST  = OW'(OFF_MIN - 1);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);
  localparam logic [OW-1:0] OFF_ONE   = OW'(1);

  logic [2:0]    lvl_stable;
  logic          lvl_valid;
  logic          level_bad;
  logic          level_ok;

  state_t        state;
  state_t        state_next;
  fault_t        code;
  fault_t        code_next;
  logic [FW-1:0] fill_cnt;
  logic [OW-1:0] off_cnt;

  level_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .lvl_in    (water_level_state),
    .lvl_stable(lvl_stable),
    .lvl_valid (lvl_valid)
  );

  // Only an accepted code can be judged; the reset value is neither good nor bad.
  always_comb begin
    level_bad = lvl_valid && !lvl_is_valid(lvl_stable);
    level_ok  = lvl_valid &&  lvl_is_valid(lvl_stable);
  end

  // Next-state and next fault code; sensor fault outranks timeout outranks high.
  always_comb begin
    state_next = state;
    code_next  = code;
    case (state)
      IDLE: begin
        if (level_bad) begin
          state_next = FAULT;
          code_next  = FC_SENSOR;
        end else if (lvl_stable == LVL_LOW) begin
          state_next = FILL;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        if (level_bad) begin
          state_next = FAULT;
          code_next  = FC_SENSOR;
        end else if (fill_cnt == FILL_LAST) begin
          state_next = FAULT;
          code_next  = FC_TIMEOUT;
        end else if (lvl_stable == LVL_HIGH) begin
          state_next = HOLDOFF;
        end else begin
          state_next = FILL;
        end
      end
      HOLDOFF: begin
        if (level_bad) begin
          state_next = FAULT;
          code_next  = FC_SENSOR;
        end else if (off_cnt == OFF_LAST) begin
          state_next = IDLE;
        end else begin
          state_next = HOLDOFF;
        end
      end
      FAULT: begin
        if (fault_ack && level_ok) begin
          state_next = HOLDOFF;
          code_next  = FC_NONE;
        end else begin
          state_next = FAULT;
        end
      end
      default: begin
        state_next = IDLE;
        code_next  = FC_NONE;
      end
    endcase
  end

  // State, fault code and drive outputs; outputs decode the next state so
  // pump_on can never disagree with ctrl_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      code    <= FC_NONE;
      pump_on <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state   <= state_next;
      code    <= code_next;
      pump_on <= (state_next == FILL);
      alarm   <= (state_next == FAULT);
    end
  end

  // Fill timer: zero on entry, counts while filling, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (state == FILL && state_next == FILL) begin
      if (fill_cnt < FILL_LAST) begin
        fill_cnt <= fill_cnt + FILL_ONE;
      end else begin
        fill_cnt <= fill_cnt;
      end
    end else begin
      fill_cnt <= '0;
    end
  end

  // Off timer: zero on entry to HOLDOFF, counts up to the minimum off time.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_cnt <= '0;
    end else if (state == HOLDOFF && state_next == HOLDOFF) begin
      if (off_cnt < OFF_LAST) begin
        off_cnt <= off_cnt + OFF_ONE;
      end else begin
        off_cnt <= off_cnt;
      end
    end else begin
      off_cnt <= '0;
    end
  end

  assign ctrl_state = state;
  assign fault_code = code;

endmodule

// File: tb/tb_pump_control.sv
// Self-checking bench for pump_control with short timing parameters.
// Each cycle the expected {pump_on, alarm, fault_code, ctrl_state} is queued
// with the stimulus; the observed value is queued after the edge, and each
// scenario task drains both queues and compares.
module tb_pump_control;

  localparam int DEB_CYC  = 4;
  localparam int FILL_MAX = 20;
  localparam int OFF_MIN  = 5;

  // {pump_on, alarm, fault_code[1:0], ctrl_state[1:0]}
  localparam logic [5:0] E_IDLE = 6'b0_0_00_00;
  localparam logic [5:0] E_FILL = 6'b1_0_00_01;
  localparam logic [5:0] E_HOLD = 6'b0_0_00_10;
  localparam logic [5:0] E_FT   = 6'b0_1_10_11;
  localparam logic [5:0] E_FS   = 6'b0_1_01_11;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] water_level_state;
  logic       fault_ack;
  logic       pump_on;
  logic       alarm;
  logic [1:0] fault_code;
  logic [1:0] ctrl_state;

  logic [5:0] exp_q[$];
  logic [5:0] act_q[$];
  int errors = 0;
  int checks = 0;

  pump_control #(
    .DEB_CYC (DEB_CYC),
    .FILL_MAX(FILL_MAX),
    .OFF_MIN (OFF_MIN)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .water_level_state(water_level_state),
    .fault_ack        (fault_ack),
    .pump_on          (pump_on),
    .alarm            (alarm),
    .fault_code       (fault_code),
    .ctrl_state       (ctrl_state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue its expectation, capture the response.
  task automatic drive(input logic r, input logic [2:0] lvl, input logic ack,
                       input logic [5:0] e);
    rst = r;
    water_level_state = lvl;
    fault_ack = ack;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    act_q.push_back({pump_on, alarm, fault_code, ctrl_state});
  endtask

  task automatic do_reset(input logic [2:0] lvl);
    drive(1'b1, lvl, 1'b0, E_IDLE);
    drive(1'b1, lvl, 1'b0, E_IDLE);
  endtask

  task automatic test_reset();
    logic [5:0] e;
    logic [5:0] a;
    int idx = 0;
    do_reset(3'b010);
    for (int k = 1; k <= 6; k++) drive(1'b0, 3'b010, 1'b0, E_IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", idx, a, e);
      end
      idx++;
    end
  endtask

  task automatic test_low_high();
    logic [5:0] e;
    logic [5:0] a;
    logic [2:0] lvl;
    int idx = 0;
    do_reset(3'b001);
    for (int k = 1; k <= 26; k++) begin
      lvl = (k <= 10) ? 3'b001 : (k <= 15) ? 3'b010 : 3'b100;
      e   = (k <= 4) ? E_IDLE : (k <= 19) ? E_FILL : (k <= 24) ? E_HOLD : E_IDLE;
      drive(1'b0, lvl, 1'b0, e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL low_high cycle %0d: got %b expected %b", idx, a, e);
      end
      idx++;
    end
  endtask

  task automatic test_glitch();
    logic [5:0] e;
    logic [5:0] a;
    logic [2:0] lvl;
    int idx = 0;
    do_reset(3'b010);
    for (int k = 1; k <= 16; k++) begin
      lvl = (k >= 7 && k <= 9) ? 3'b001 : 3'b010;
      drive(1'b0, lvl, 1'b0, E_IDLE);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL glitch cycle %0d: got %b expected %b", idx, a, e);
      end
      idx++;
    end
  endtask

  task automatic test_timeout();
    logic [5:0] e;
    logic [5:0] a;
    int idx = 0;
    do_reset(3'b001);
    for (int k = 1; k <= 35; k++) begin
      e = (k <= 4)  ? E_IDLE : (k <= 24) ? E_FILL : (k <= 27) ? E_FT :
          (k <= 32) ? E_HOLD : (k == 33) ? E_IDLE : E_FILL;
      drive(1'b0, 3'b001, (k == 28), e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %b expected %b", idx, a, e);
      end
      idx++;
    end
  endtask

  task automatic test_sensor();
    logic [5:0] e;
    logic [5:0] a;
    logic [2:0] lvl;
    int idx = 0;
    do_reset(3'b001);
    for (int k = 1; k <= 25; k++) begin
      lvl = (k < 8) ? 3'b001 : (k <= 14) ? 3'b000 : 3'b100;
      e   = (k <= 4) ? E_IDLE : (k <= 11) ? E_FILL : (k <= 18) ? E_FS :
            (k <= 23) ? E_HOLD : E_IDLE;
      drive(1'b0, lvl, (k >= 13 && k <= 19), e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sensor cycle %0d: got %b expected %b", idx, a, e);
      end
      idx++;
    end
  endtask

  task automatic test_priority();
    logic [5:0] e;
    logic [5:0] a;
    logic [2:0] lvl;
    int idx = 0;
    do_reset(3'b001);
    for (int k = 1; k <= 26; k++) begin
      lvl = (k < 21) ? 3'b001 : 3'b110;
      e   = (k <= 4) ? E_IDLE : (k <= 24) ? E_FILL : E_FS;
      drive(1'b0, lvl, 1'b0, e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL priority cycle %0d: got %b expected %b", idx, a, e);
      end
      idx++;
    end
  endtask

  task automatic test_reset_override();
    logic [5:0] e;
    logic [5:0] a;
    int idx = 0;
    do_reset(3'b001);
    for (int k = 1; k <= 36; k++) begin
      e = (k <= 4)  ? E_IDLE : (k <= 7)  ? E_FILL : (k <= 12) ? E_IDLE :
          (k <= 32) ? E_FILL : (k == 33) ? E_FT   : E_IDLE;
      drive((k == 8 || k == 34), 3'b001, (k == 34), e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_override cycle %0d: got %b expected %b", idx, a, e);
      end
      idx++;
    end
  endtask

  initial begin
    rst = 1'b1;
    water_level_state = 3'b000;
    fault_ack = 1'b0;
    test_reset();
    test_low_high();
    test_glitch();
    test_timeout();
    test_sensor();
    test_priority();
    test_reset_override();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
